cle_key_reader: RTL and testbench

- Host-side sequencer that drives the serial security PAL (the CLE1 key state machine) from the main clock domain.
- It emits the bus select, address and strobe pattern the PAL clocks on: first a programmable unlock-key nibble sequence on BA7..BA4, then DATA_BITS read strobes. On each read strobe it samples SDRD and shifts the bit into a result word.
- It is the stage directly upstream of the PAL: it generates every bus cycle that advances the PAL state and consumes the SDRD bit the PAL produces.
- The assembled word is handed to the CPU side over a valid/ready handshake.

---
 rtl/cle_key_reader.sv | 154 +++++++++++++++
 tb/tb_cle_key_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cle_key_reader.sv
// cle_key_reader: host-side sequencer for the CLE1 serial security PAL.
// Clocks a programmable unlock-key nibble sequence into the PAL, then shifts DATA_BITS of SDRD into a word.
module cle_key_reader #(
    parameter int KEY_LEN    = 4,
    parameter int DATA_BITS  = 16,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*KEY_LEN-1:0] key_seq,
    input  logic                 sdrd,
    output logic                 sser_n,
    output logic                 ba13,
    output logic                 ba12,
    output logic [3:0]           ba7_4,
    output logic                 br_w,
    output logic                 key_clk,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy
);
    localparam int CW = $clog2(SETUP_CYC + STROBE_CYC + 1);
    localparam int IW = $clog2(KEY_LEN + 1);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE, KSETUP, KSTROBE, RSETUP, RSTROBE, DONE
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cyc;
    logic [IW-1:0]        r_idx;
    logic [BW-1:0]        r_bit;
    logic [4*KEY_LEN-1:0] r_key;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_sser_n;
    logic                 r_ba12;
    logic [3:0]           r_ba7_4;
    logic                 r_br_w;
    logic                 r_key_clk;
    logic                 r_valid;
    logic                 r_busy;
    logic [4*KEY_LEN-1:0] w_key_next;

    // Remaining nibbles slide down so the next one is always in the low four bits.
    assign w_key_next = r_key >> 4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cyc     <= '0;
            r_idx     <= '0;
            r_bit     <= '0;
            r_key     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_sser_n  <= 1'b1;
            r_ba12    <= 1'b0;
            r_ba7_4   <= 4'h0;
            r_br_w    <= 1'b0;
            r_key_clk <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_key     <= key_seq;
                        r_idx     <= '0;
                        r_bit     <= '0;
                        r_cyc     <= '0;
                        r_shift   <= '0;
                        r_busy    <= 1'b1;
                        r_sser_n  <= 1'b0;
                        r_ba12    <= 1'b1;
                        r_br_w    <= 1'b1;
                        r_ba7_4   <= key_seq[3:0];
                        r_key_clk <= 1'b0;
                        r_state   <= KSETUP;
                    end
                end
                KSETUP, RSETUP: begin
                    if (r_cyc == CW'(SETUP_CYC - 1)) begin
                        // SDRD is captured on the same edge that raises key_clk.
                        if (r_state == RSETUP) begin
                            r_shift <= DATA_BITS'({r_shift, sdrd});
                        end
                        r_key_clk <= 1'b1;
                        r_cyc     <= '0;
                        r_state   <= (r_state == KSETUP) ? KSTROBE : RSTROBE;
                    end else begin
                        r_cyc <= r_cyc + CW'(1);
                    end
                end
                KSTROBE, RSTROBE: begin
                    if (r_cyc == CW'(STROBE_CYC)) begin
                        r_cyc <= '0;
                        if (r_state == KSTROBE) begin
                            if (r_idx == IW'(KEY_LEN - 1)) begin
                                r_ba7_4 <= 4'h0;
                                r_state <= RSETUP;
                            end else begin
                                r_idx   <= r_idx + IW'(1);
                                r_key   <= w_key_next;
                                r_ba7_4 <= w_key_next[3:0];
                                r_state <= KSETUP;
                            end
                        end else if (r_bit == BW'(DATA_BITS - 1)) begin
                            r_sser_n <= 1'b1;
                            r_ba12   <= 1'b0;
                            r_br_w   <= 1'b0;
                            r_ba7_4  <= 4'h0;
                            r_data   <= r_shift;
                            r_valid  <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_bit   <= r_bit + BW'(1);
                            r_state <= RSETUP;
                        end
                    end else begin
                        // Address stays put through the low cycle after the strobe.
                        if (r_cyc == CW'(STROBE_CYC - 1)) begin
                            r_key_clk <= 1'b0;
                        end
                        r_cyc <= r_cyc + CW'(1);
                    end
                end
                DONE: begin
                    if (data_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sser_n     = r_sser_n;
    assign ba13       = 1'b0;
    assign ba12       = r_ba12;
    assign ba7_4      = r_ba7_4;
    assign br_w       = r_br_w;
    assign key_clk    = r_key_clk;
    assign data       = r_data;
    assign data_valid = r_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_cle_key_reader.sv
// Bench for cle_key_reader: three instances (default, fast timing, minimal sizes) checked against
// a bus-level reference model that watches key_clk edges and the SDRD value present at each rise.
module tb_cle_key_reader;
    logic        clk;
    logic        rst_n;
    logic        start [3];
    logic [31:0] key   [3];
    logic        sdrd  [3];
    logic        rdy   [3];
    logic        ss    [3];
    logic        b13   [3];
    logic        b12   [3];
    logic [3:0]  ba    [3];
    logic        brw   [3];
    logic        kc    [3];
    logic        dv    [3];
    logic        bsy   [3];
    logic [31:0] dat   [3];
    logic [15:0] d0_data;
    logic [7:0]  d1_data;
    logic [0:0]  d2_data;

    int KL  [3] = '{4, 3, 1};
    int DB  [3] = '{16, 8, 1};
    int PER [3] = '{5, 3, 5};

    int n_checks;
    int n_errors;

    // reference model state
    int          rises  [3] = '{0, 0, 0};
    int          txn_r  [3] = '{0, 0, 0};
    logic [31:0] samp   [3];
    logic [3:0]  nib_seen [3][64];
    logic        p_kc [3], p_ss [3], p_b12 [3], p_brw [3], p_sd [3];
    logic [3:0]  p_ba [3];
    logic        prev_rst = 1'b0;

    logic        pat_mode;
    logic [15:0] pat;
    int          nom_base;
    int          rd;

    cle_key_reader u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .key_seq(key[0][15:0]), .sdrd(sdrd[0]),
        .sser_n(ss[0]), .ba13(b13[0]), .ba12(b12[0]), .ba7_4(ba[0]), .br_w(brw[0]),
        .key_clk(kc[0]), .data(d0_data), .data_valid(dv[0]), .data_ready(rdy[0]), .busy(bsy[0])
    );

    cle_key_reader #(.KEY_LEN(3), .DATA_BITS(8), .SETUP_CYC(1), .STROBE_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .key_seq(key[1][11:0]), .sdrd(sdrd[1]),
        .sser_n(ss[1]), .ba13(b13[1]), .ba12(b12[1]), .ba7_4(ba[1]), .br_w(brw[1]),
        .key_clk(kc[1]), .data(d1_data), .data_valid(dv[1]), .data_ready(rdy[1]), .busy(bsy[1])
    );

    cle_key_reader #(.KEY_LEN(1), .DATA_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .key_seq(key[2][3:0]), .sdrd(sdrd[2]),
        .sser_n(ss[2]), .ba13(b13[2]), .ba12(b12[2]), .ba7_4(ba[2]), .br_w(brw[2]),
        .key_clk(kc[2]), .data(d2_data), .data_valid(dv[2]), .data_ready(rdy[2]), .busy(bsy[2])
    );

    assign dat[0] = 32'(d0_data);
    assign dat[1] = 32'(d1_data);
    assign dat[2] = 32'(d2_data);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // SDRD drivers: pattern or per-cycle random for instance 0, random for 1, constant 1 for 2.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rd = rises[0] - nom_base - KL[0];
            if (pat_mode && rd >= 0 && rd < 16) sdrd[0] = pat[15 - rd];
            else sdrd[0] = 1'($urandom);
            sdrd[1] = 1'($urandom);
            sdrd[2] = 1'b1;
        end
    end

    // Bus monitor: the PAL latches on each key_clk rise; the bit it hands back is whatever
    // SDRD held in the cycle before that rise.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && prev_rst) begin
                if (p_ss[i] && !ss[i]) begin
                    txn_r[i] <= 0;
                end else if (kc[i] && !p_kc[i]) begin
                    txn_r[i] <= txn_r[i] + 1;
                    if (txn_r[i] >= KL[i]) samp[i] <= {samp[i][30:0], p_sd[i]};
                end
                if (kc[i] && !p_kc[i]) begin
                    nib_seen[i][rises[i] % 64] <= ba[i];
                    rises[i] <= rises[i] + 1;
                end
                if (kc[i] || p_kc[i])
                    chk("addr_hold", 64'({ba[i], ss[i], b12[i], brw[i]}),
                        64'({p_ba[i], p_ss[i], p_b12[i], p_brw[i]}));
            end
            p_kc[i]  <= kc[i];
            p_ss[i]  <= ss[i];
            p_b12[i] <= b12[i];
            p_brw[i] <= brw[i];
            p_ba[i]  <= ba[i];
            p_sd[i]  <= sdrd[i];
        end
        prev_rst <= rst_n;
    end

    task automatic run_txn(input int i, input logic [31:0] k, output int lat, output int rbase);
        rbase    = rises[i];
        key[i]   = k;
        start[i] = 1'b1;
        @(posedge clk);
        #1 start[i] = 1'b0;
        lat = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            if (dv[i]) break;
        end
    endtask

    task automatic check_result(input int i, input logic [31:0] k, input int lat, input int rbase);
        logic [63:0] mask;
        mask = (64'd1 << DB[i]) - 64'd1;
        chk($sformatf("latency%0d", i), 64'(lat), 64'((KL[i] + DB[i]) * PER[i] + 1));
        chk($sformatf("rises%0d", i), 64'(rises[i] - rbase), 64'(KL[i] + DB[i]));
        for (int j = 0; j < KL[i]; j++)
            chk($sformatf("nibble%0d_%0d", i, j), 64'(nib_seen[i][(rbase + j) % 64]),
                64'((k >> (4 * j)) & 32'hF));
        chk($sformatf("data%0d", i), 64'(dat[i]), 64'(samp[i]) & mask);
    endtask

    int          lat;
    int          base;
    int          n;
    logic [31:0] k;
    logic [31:0] held;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        pat_mode = 1'b0;
        pat      = 16'hB3E1;
        nom_base = 0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            key[i]   = '0;
            rdy[i]   = 1'b1;
            samp[i]  = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sser_n", 64'(ss[0]), 64'd1);
        chk("rst_ba13", 64'(b13[0]), 64'd0);
        chk("rst_ba12", 64'(b12[0]), 64'd0);
        chk("rst_ba7_4", 64'(ba[0]), 64'd0);
        chk("rst_br_w", 64'(brw[0]), 64'd0);
        chk("rst_key_clk", 64'(kc[0]), 64'd0);
        chk("rst_data", 64'(dat[0]), 64'd0);
        chk("rst_valid", 64'(dv[0]), 64'd0);
        chk("rst_busy", 64'(bsy[0]), 64'd0);
        chk("rst_dut1", 64'({ss[1], kc[1], dv[1], bsy[1]}), 64'b1000);
        chk("rst_dut2", 64'({ss[2], kc[2], dv[2], bsy[2]}), 64'b1000);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle", 64'({ss[0], kc[0], bsy[0]}), 64'b100);
        end

        // nominal read with the fixed key and SDRD pattern
        nom_base = rises[0];
        pat_mode = 1'b1;
        run_txn(0, 32'h9A5C, lat, base);
        chk("nom_latency", 64'(lat), 64'd101);
        chk("nom_data", 64'(dat[0]), 64'h B3E1);
        chk("nom_nibbles", 64'({nib_seen[0][base % 64], nib_seen[0][(base + 1) % 64],
                                nib_seen[0][(base + 2) % 64], nib_seen[0][(base + 3) % 64]}),
            64'h C5A9);
        check_result(0, 32'h9A5C, lat, base);
        @(negedge clk);
        chk("nom_accept", 64'({dv[0], bsy[0]}), 64'b00);
        pat_mode = 1'b0;

        // backpressure with a start pulse while the result waits
        rdy[0] = 1'b0;
        k = $urandom & 32'hFFFF;
        run_txn(0, k, lat, base);
        check_result(0, k, lat, base);
        held = dat[0];
        for (int c = 0; c < 10; c++) begin
            start[0] = (c == 3);
            @(negedge clk);
            chk("bp_hold", 64'({dv[0], bsy[0], dat[0]}), 64'({2'b11, held}));
        end
        rdy[0]   = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("bp_release", 64'({dv[0], bsy[0]}), 64'b00);
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_queue", 64'({ss[0], bsy[0]}), 64'b10);
        end

        // randomized transactions on all three instances
        for (int t = 0; t < 2; t++) begin
            k = $urandom & 32'hFFFF;
            run_txn(0, k, lat, base);
            check_result(0, k, lat, base);
            @(negedge clk);
        end
        for (int t = 0; t < 4; t++) begin
            k = $urandom & 32'hFFF;
            run_txn(1, k, lat, base);
            check_result(1, k, lat, base);
            @(negedge clk);
        end
        for (int t = 0; t < 2; t++) begin
            k = $urandom & 32'hF;
            run_txn(2, k, lat, base);
            check_result(2, k, lat, base);
            chk("edge_data", 64'(dat[2]), 64'd1);
            @(negedge clk);
        end

        // reset in the middle of the third key strobe
        k = $urandom & 32'hFFFF;
        base     = rises[0];
        key[0]   = k;
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        n = 0;
        while (n < 200 && !((rises[0] - base) == 3 && kc[0])) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach", 64'(n < 200), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_async", 64'({kc[0], ss[0], bsy[0], dv[0], ba[0]}), 64'({4'b0100, 4'h0}));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        k = $urandom & 32'hFFFF;
        run_txn(0, k, lat, base);
        check_result(0, k, lat, base);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
